// File: rtl/video_fmt_pkg.sv
// Shared definitions for the video format path: detector format codes and the
// stabiliser lock-state encoding.
`timescale 1ns/1ps
package video_fmt_pkg;

    localparam logic [7:0] FMT_NONE    = 8'h00;
    localparam logic [7:0] FMT_576I50  = 8'h01;
    localparam logic [7:0] FMT_480I60  = 8'h02;
    localparam logic [7:0] FMT_576P50  = 8'h03;
    localparam logic [7:0] FMT_480P60  = 8'h04;
    localparam logic [7:0] FMT_1080I50 = 8'h0B;
    localparam logic [7:0] FMT_1080I60 = 8'h0C;
    localparam logic [7:0] FMT_720P50  = 8'h12;
    localparam logic [7:0] FMT_720P60  = 8'h13;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } stab_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Parameterised-width two-flop synchroniser for signals arriving from another
// clock domain; output is cleared by the asynchronous reset.
`timescale 1ns/1ps
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbour, which is what makes this a 2-stage chain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/video_format_stabilizer.sv
// Debounces the detector format code into a locked format with loss/timeout
// handling and a single-entry change-event buffer. Optional sticky overrun
// output is enabled with the FORMAT_OVERRUN_FLAG_EN macro.
`timescale 1ns/1ps
module video_format_stabilizer
    import video_fmt_pkg::*;
#(
    parameter int STABLE_FRAMES  = 4,
    parameter int TIMEOUT_CYCLES = 2_500_000
) (
    input  logic       clk_50mhz_in,
    input  logic       reset_n_in,
    input  logic       vsync_in,
    input  logic       sample_in,
    input  logic [7:0] format_in,
    output logic [7:0] format_out,
    output logic       format_valid_out,
    output logic       event_valid_out,
    input  logic       event_ready_in,
    output logic [7:0] event_format_out
`ifdef FORMAT_OVERRUN_FLAG_EN
    ,
    output logic       overrun_out
`endif
);

    localparam int              CW       = $clog2(STABLE_FRAMES + 1);
    localparam logic [CW-1:0]   LOCK_CNT = CW'(STABLE_FRAMES);
    localparam logic [31:0]     TMO_MAX  = 32'(TIMEOUT_CYCLES);

    logic        vsync_s;
    logic        sample_s;
    logic [7:0]  format_s;
    logic        vsync_d;
    logic        tick;

    stab_state_e state, state_nx;
    logic [7:0]  cand, cand_nx;
    logic [CW-1:0] count, count_nx, run_cnt;
    logic [31:0] tmo, tmo_nx;
    logic [7:0]  fmt_q, fmt_nx;
    logic        loss;
    logic        push;
    logic        ev_valid;
    logic [7:0]  ev_fmt;

    sync_2ff #(.WIDTH(1)) u_sync_vsync (
        .clk(clk_50mhz_in), .reset_n(reset_n_in), .d(vsync_in), .q(vsync_s)
    );
    sync_2ff #(.WIDTH(1)) u_sync_sample (
        .clk(clk_50mhz_in), .reset_n(reset_n_in), .d(sample_in), .q(sample_s)
    );
    sync_2ff #(.WIDTH(8)) u_sync_format (
        .clk(clk_50mhz_in), .reset_n(reset_n_in), .d(format_in), .q(format_s)
    );

    // Loss has priority over any tick in the same cycle.
    assign loss = !sample_s || (tmo == TMO_MAX);
    assign push = (fmt_nx != fmt_q);

    always_comb begin
        // NOTE: every value assigned here gets a default first, so no path
        // through the branches below can infer a latch.
        state_nx = state;
        cand_nx  = cand;
        count_nx = count;
        fmt_nx   = fmt_q;
        tmo_nx   = tmo;
        run_cnt  = '0;

        if (loss) begin
            state_nx = IDLE;
            cand_nx  = FMT_NONE;
            count_nx = '0;
            fmt_nx   = FMT_NONE;
            tmo_nx   = '0;
        end else begin
            if (state == IDLE || tick)
                tmo_nx = '0;
            else if (tmo != TMO_MAX)
                tmo_nx = tmo + 32'd1;

            if (tick && !(state == LOCKED && format_s == fmt_q)) begin
                if (format_s == FMT_NONE) begin
                    // A zero code while acquiring restarts the run; IDLE ignores it.
                    if (state != IDLE)
                        state_nx = ACQUIRE;
                    cand_nx  = FMT_NONE;
                    count_nx = '0;
                end else begin
                    run_cnt  = (state == ACQUIRE && format_s == cand) ? count + 1'b1 : CW'(1);
                    cand_nx  = format_s;
                    count_nx = run_cnt;
                    if (run_cnt == LOCK_CNT) begin
                        state_nx = LOCKED;
                        fmt_nx   = format_s;
                    end else begin
                        state_nx = ACQUIRE;
                    end
                end
            end
        end
    end

    // NOTE: every flop here, payload included, is reset so a pending event
    // cannot survive a reset with stale contents.
    always_ff @(posedge clk_50mhz_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            vsync_d  <= 1'b0;
            tick     <= 1'b0;
            state    <= IDLE;
            cand     <= FMT_NONE;
            count    <= '0;
            tmo      <= '0;
            fmt_q    <= FMT_NONE;
            ev_valid <= 1'b0;
            ev_fmt   <= FMT_NONE;
        end else begin
            vsync_d  <= vsync_s;
            tick     <= vsync_s && !vsync_d;
            state    <= state_nx;
            cand     <= cand_nx;
            count    <= count_nx;
            tmo      <= tmo_nx;
            fmt_q    <= fmt_nx;
            // A push always wins over acceptance, so valid stays high when both coincide.
            ev_valid <= push || (ev_valid && !event_ready_in);
            if (push)
                ev_fmt <= fmt_nx;
        end
    end

`ifdef FORMAT_OVERRUN_FLAG_EN
    always_ff @(posedge clk_50mhz_in or negedge reset_n_in) begin
        if (!reset_n_in)
            overrun_out <= 1'b0;
        else if (push && ev_valid && !event_ready_in)
            overrun_out <= 1'b1;
    end
`endif

    assign format_out       = fmt_q;
    assign format_valid_out = (state == LOCKED);
    assign event_valid_out  = ev_valid;
    assign event_format_out = ev_fmt;

endmodule
